// File: rtl/mem_read_arbiter.sv
// Purpose: shares one memory read port between the instruction-read and data-read channels.
// Latency: address path is registered (1 cycle); return path is combinational (0 cycles).
// Backpressure: address readies drop while the request slot is held or MAX_OUTSTANDING tags are pending.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               ir_addr_valid,
    output logic                               ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0]              ir_addr,
    input  logic                               dr_addr_valid,
    output logic                               dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0]              dr_addr,
    output logic                               m_addr_valid,
    input  logic                               m_addr_ready,
    output logic [ADDR_WIDTH-1:0]              m_addr,
    input  logic                               m_data_valid,
    output logic                               m_data_ready,
    input  logic [DATA_WIDTH-1:0]              m_data,
    output logic                               ir_data_valid,
    input  logic                               ir_data_ready,
    output logic [DATA_WIDTH-1:0]              ir_data,
    output logic                               dr_data_valid,
    input  logic                               dr_data_ready,
    output logic [DATA_WIDTH-1:0]              dr_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               protocol_err
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Tag encoding: 0 = instruction read, 1 = data read.
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    logic          tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          last_grant;

    logic          slot_free;
    logic          can_issue;
    logic          grant_data;
    logic          issue;
    logic          fifo_empty;
    logic          head_tag;
    logic          pop;

    assign slot_free  = !m_addr_valid || m_addr_ready;
    // No bypass: a full tag FIFO blocks issue even when a pop lands the same cycle.
    assign can_issue  = slot_free && (count < MAX_CNT);
    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];
    assign outstanding = count;
    assign ir_data    = m_data;
    assign dr_data    = m_data;

    // Round-robin grant: a tie goes to the requester that did not win last time.
    always_comb begin
        grant_data = TAG_INST;
        if (ir_addr_valid && dr_addr_valid) begin
            grant_data = (last_grant == TAG_DATA) ? TAG_INST : TAG_DATA;
        end else if (dr_addr_valid) begin
            grant_data = TAG_DATA;
        end
        ir_addr_ready = can_issue && (grant_data == TAG_INST);
        dr_addr_ready = can_issue && (grant_data == TAG_DATA);
        issue         = (ir_addr_valid && ir_addr_ready) || (dr_addr_valid && dr_addr_ready);
    end

    // Route the returning beat by the oldest pending tag; drain beats nobody asked for.
    always_comb begin
        ir_data_valid = 1'b0;
        dr_data_valid = 1'b0;
        m_data_ready  = 1'b1;
        if (!fifo_empty) begin
            if (head_tag == TAG_INST) begin
                ir_data_valid = m_data_valid;
                m_data_ready  = ir_data_ready;
            end else begin
                dr_data_valid = m_data_valid;
                m_data_ready  = dr_data_ready;
            end
        end
        pop = m_data_valid && m_data_ready && !fifo_empty;
    end

    // Registered memory request slot: held stable until the memory accepts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_addr_valid <= 1'b0;
            m_addr       <= '0;
            last_grant   <= TAG_DATA;
        end else if (issue) begin
            m_addr_valid <= 1'b1;
            m_addr       <= (grant_data == TAG_DATA) ? dr_addr : ir_addr;
            last_grant   <= grant_data;
        end else if (m_addr_ready) begin
            m_addr_valid <= 1'b0;
        end
    end

    // Tag FIFO pointers, occupancy and the sticky unexpected-data flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (issue) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(issue) - CW'(pop);
            if (m_data_valid && fifo_empty) protocol_err <= 1'b1;
        end
    end

    // Tag storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (issue) tag_mem[wr_ptr] <= grant_data;
    end

endmodule
